// File: rtl/level_controller_if.sv
// level_controller_if: debounced encoder/select inputs and per-channel level outputs.
interface level_controller_if #(parameter int NUM_LEDS = 3);
  logic a, b, sel, en;
  logic [NUM_LEDS*8-1:0] levels;
  logic [NUM_LEDS-1:0] active;
  logic update;
  modport master (output a, b, sel, en, input levels, active, update);
  modport slave (input a, b, sel, en, output levels, active, update);
endinterface

// File: rtl/level_controller.sv
// level_controller: routes one encoder to NUM_LEDS brightness registers, select button cycles the active channel.
module level_controller #(
  parameter int NUM_LEDS = 3,
  parameter int STEP = 1,
  parameter bit WRAP = 1'b0
) (
  input logic clk,
  input logic reset,
  level_controller_if.slave io
);
  localparam int IW = $clog2(NUM_LEDS);
  logic a_q, b_q, sel_q, a_p, sel_p;
  logic [1:0] arm_q, arm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] lvl_q [NUM_LEDS];
  logic [7:0] lvl_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] act_q, act_d;
  logic upd_q, upd_d;
  logic step, pick;
  logic [7:0] cur, nxt;
  logic [8:0] sum;
  always_comb begin
    step = a_q & ~a_p & arm_q[1];
    pick = sel_q & ~sel_p & arm_q[1];
    arm_d = arm_q[1] ? arm_q : arm_q + 2'd1;
    cur = lvl_q[idx_q];
    // bit 8 flags overflow on increment and borrow on decrement
    sum = b_q ? {1'b0, cur} - 9'(STEP) : {1'b0, cur} + 9'(STEP);
    nxt = (WRAP || !sum[8]) ? sum[7:0] : (b_q ? 8'h00 : 8'hFF);
    upd_d = step & io.en & (nxt != cur);
    lvl_d = lvl_q;
    if (upd_d) lvl_d[idx_q] = nxt;
    idx_d = pick ? (idx_q == IW'(NUM_LEDS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    act_d = NUM_LEDS'(1) << idx_d;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
      sel_q <= 1'b0;
      a_p <= 1'b0;
      sel_p <= 1'b0;
      arm_q <= '0;
      idx_q <= '0;
      act_q <= NUM_LEDS'(1);
      upd_q <= 1'b0;
      lvl_q <= '{default: '0};
    end else begin
      a_q <= io.a;
      b_q <= io.b;
      sel_q <= io.sel;
      a_p <= a_q;
      sel_p <= sel_q;
      arm_q <= arm_d;
      idx_q <= idx_d;
      act_q <= act_d;
      upd_q <= upd_d;
      lvl_q <= lvl_d;
    end
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lv
    assign io.levels[8*i +: 8] = lvl_q[i];
  end
  assign io.active = act_q;
  assign io.update = upd_q;
endmodule
